// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: unit classes, FSM states,
// opcode field widths.
package alu_pkg;

    localparam int OP_W    = 4;
    localparam int CLASS_W = 2;
    localparam int FUN_W   = 2;

    localparam logic [CLASS_W-1:0] ARITH = 2'b00;
    localparam logic [CLASS_W-1:0] LOGIC = 2'b01;
    localparam logic [CLASS_W-1:0] CMP   = 2'b10;
    localparam logic [CLASS_W-1:0] SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } ctrl_state_t;

    function automatic logic [CLASS_W-1:0] class_of(input logic [OP_W-1:0] op);
        return op[OP_W-1:OP_W-CLASS_W];
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational class decoder: turns the stored unit class and the issue
// strobe into one-hot (or all-zero) unit enables.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [CLASS_W-1:0] op_class,
    input  logic               issue,
    output logic               arith_en,
    output logic               logic_en,
    output logic               cmp_en,
    output logic               shift_en
);

    logic [(1<<CLASS_W)-1:0] en_vec;

    for (genvar gi = 0; gi < (1 << CLASS_W); gi++) begin : g_en
        assign en_vec[gi] = issue && (op_class == CLASS_W'(gi));
    end

    assign arith_en = en_vec[ARITH];
    assign logic_en = en_vec[LOGIC];
    assign cmp_en   = en_vec[CMP];
    assign shift_en = en_vec[SHIFT];

endmodule

// File: rtl/alu_ctrl_unit.sv
// ALU command front-end: accepts one op, issues it to the selected unit for a
// single cycle, captures result/flag and holds it until taken downstream.
// Optional completed-operation counter enabled by `define ALU_CTRL_OP_COUNT_EN.
module alu_ctrl_unit
    import alu_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [width-1:0] cmd_a,
    input  logic [width-1:0] cmd_b,
    output logic [width-1:0] A,
    output logic [width-1:0] B,
    output logic [FUN_W-1:0] alu_fun,
    output logic             arith_EN,
    output logic             logic_EN,
    output logic             cmp_EN,
    output logic             shift_EN,
    input  logic [width-1:0] arith_out,
    input  logic [width-1:0] logic_out,
    input  logic [width-1:0] cmp_out,
    input  logic [width-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [width-1:0] res_data,
    output logic             res_flag,
    output logic [15:0]      op_count
);

    ctrl_state_t      state_reg, state_next;
    logic [width-1:0] a_reg, b_reg;
    logic [OP_W-1:0]  op_reg;
    logic             flag_reg;
    logic [width-1:0] res_data_reg;
    logic             res_flag_reg;
    logic             issue;
    logic [width-1:0] sel_out;
    logic             sel_flag;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            flag_reg     <= 1'b0;
            res_data_reg <= '0;
            res_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && cmd_valid) begin
                a_reg  <= cmd_a;
                b_reg  <= cmd_b;
                op_reg <= cmd_op;
            end
            // Unit flags are combinational and only meaningful while enabled.
            if (state_reg == ISSUE)
                flag_reg <= sel_flag;
            if (state_reg == CAPTURE) begin
                res_data_reg <= sel_out;
                res_flag_reg <= flag_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_next = ISSUE;
            end
            ISSUE: begin
                issue      = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: state_next = RESP;
            RESP: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results are selected by stored class, never ORed across units.
    always_comb begin
        sel_out  = '0;
        sel_flag = 1'b0;
        case (class_of(op_reg))
            ARITH: begin sel_out = arith_out; sel_flag = arith_flag; end
            LOGIC: begin sel_out = logic_out; sel_flag = logic_flag; end
            CMP:   begin sel_out = cmp_out;   sel_flag = cmp_flag;   end
            SHIFT: begin sel_out = shift_out; sel_flag = shift_flag; end
        endcase
    end

    alu_op_decoder u_dec (
        .op_class (class_of(op_reg)),
        .issue    (issue),
        .arith_en (arith_EN),
        .logic_en (logic_EN),
        .cmp_en   (cmp_EN),
        .shift_en (shift_EN)
    );

    assign A        = a_reg;
    assign B        = b_reg;
    assign alu_fun  = op_reg[FUN_W-1:0];
    assign res_data = res_data_reg;
    assign res_flag = res_flag_reg;

`ifdef ALU_CTRL_OP_COUNT_EN
    logic [15:0] op_count_reg;

    always_ff @(posedge clk or posedge rest) begin
        if (rest)
            op_count_reg <= '0;
        else if (res_valid && res_ready)
            op_count_reg <= op_count_reg + 16'd1;
    end

    assign op_count = op_count_reg;
`else
    assign op_count = '0;
`endif

endmodule
